// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI3 RAM responder.
// Holds the AXI burst and response encodings, the read/write FSM state
// types, the legality check for a request and the per-beat address stepper.
// No ports: this file is a package imported by the RTL.
package axi_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [1:0] rdState_t;
   localparam rdState_t R_IDLE  = 2'd0;
   localparam rdState_t R_FETCH = 2'd1;
   localparam rdState_t R_DATA  = 2'd2;

   typedef logic [1:0] wrState_t;
   localparam wrState_t W_IDLE = 2'd0;
   localparam wrState_t W_DATA = 2'd1;
   localparam wrState_t W_RESP = 2'd2;

   // A request is refused when the burst type is reserved, the beat is
   // wider than the 32-bit bus, or a WRAP burst has a length AXI forbids.
   function automatic logic isIllegal(input logic [1:0] burst,
                                      input logic [2:0] size,
                                      input logic [3:0] len);
      logic bad;
      bad = (burst == 2'b11) || (size > 3'd2);
      if ((burst == BURST_WRAP) &&
          !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15)))
         bad = 1'b1;
      return bad;
   endfunction

   // Address of the beat following addr. WRAP keeps the upper bits of the
   // aligned (len+1)<<size window and lets only the offset roll over.
   function automatic logic [31:0] nextAddr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [3:0]  len,
                                            input logic [1:0]  burst);
      logic [31:0] incr;
      logic [31:0] winMask;
      logic [31:0] nxt;
      incr    = 32'd1 << size;
      winMask = ((({28'd0, len}) + 32'd1) << size) - 32'd1;
      case (burst)
         BURST_INCR: nxt = addr + incr;
         BURST_WRAP: nxt = (addr & ~winMask) | ((addr + incr) & winMask);
         default:    nxt = addr;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/axi_ram_slave_mem.sv
// Simple dual-port synchronous word RAM used as the responder's storage.
// Ports: clk_i/reset_i (sync, active-high, clears only the read register),
//        wrEn_i/wrBe_i/wrAddr_i/wrData_i  byte-enabled write port,
//        rdEn_i/rdAddr_i/rdData_o         registered read port, 1-cycle latency.
// A read and write to the same word on one edge returns the old contents.
module axi_ram_slave_mem #(
   parameter int MEM_AW = 12
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wrEn_i,
   input  logic [3:0]        wrBe_i,
   input  logic [MEM_AW-1:0] wrAddr_i,
   input  logic [31:0]       wrData_i,
   input  logic              rdEn_i,
   input  logic [MEM_AW-1:0] rdAddr_i,
   output logic [31:0]       rdData_o
);

   logic [31:0] mem [0:(2**MEM_AW)-1];
   logic [31:0] rdData_q;

   // Byte-lane writes; the array itself is never reset so contents survive.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (wrEn_i && wrBe_i[b])
            mem[wrAddr_i][8*b +: 8] <= wrData_i[8*b +: 8];
      end
   end

   // Read register; non-blocking update of the array gives read-first.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         rdData_q <= '0;
      else if (rdEn_i)
         rdData_q <= mem[rdAddr_i];
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder with one outstanding read and one outstanding write.
// Ports: aclk/areset (sync, active-high), AR/R read channels, AW/W/B write
//        channels. The read and write FSMs run independently and share only
//        the dual-port RAM. Lock/cache/prot and wid are accepted but unused.
module axi_ram_slave
   import axi_slave_pkg::*;
#(
   parameter int MEM_AW = 12
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   rdState_t    rdState_q, rdState_d;
   logic [3:0]  rId_q, rId_d;
   logic [31:0] rAddr_q, rAddr_d;
   logic [3:0]  rLen_q, rLen_d;
   logic [2:0]  rSize_q, rSize_d;
   logic [1:0]  rBurst_q, rBurst_d;
   logic [3:0]  rBeat_q, rBeat_d;
   logic        rErr_q, rErr_d;

   wrState_t    wrState_q, wrState_d;
   logic [3:0]  wId_q, wId_d;
   logic [31:0] wAddr_q, wAddr_d;
   logic [3:0]  wLen_q, wLen_d;
   logic [2:0]  wSize_q, wSize_d;
   logic [1:0]  wBurst_q, wBurst_d;
   logic [4:0]  wBeat_q, wBeat_d;
   logic        wErr_q, wErr_d;
   logic        bErr_q, bErr_d;

   logic        memRdEn;
   logic        memWrEn;
   logic [31:0] memRdata;
   logic        unusedInputs;

   assign unusedInputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

   // Read path: accept a request, then alternate fetch/present per beat.
   always_comb begin
      rdState_d = rdState_q;
      rId_d     = rId_q;
      rAddr_d   = rAddr_q;
      rLen_d    = rLen_q;
      rSize_d   = rSize_q;
      rBurst_d  = rBurst_q;
      rBeat_d   = rBeat_q;
      rErr_d    = rErr_q;
      case (rdState_q)
         R_IDLE: begin
            if (arvalid) begin
               rId_d     = arid;
               rAddr_d   = araddr;
               rLen_d    = arlen;
               rSize_d   = arsize;
               rBurst_d  = arburst;
               rBeat_d   = 4'd0;
               rErr_d    = isIllegal(arburst, arsize, arlen);
               rdState_d = R_FETCH;
            end
         end
         R_FETCH: rdState_d = R_DATA;
         R_DATA: begin
            if (rready) begin
               if (rBeat_q == rLen_q) begin
                  rdState_d = R_IDLE;
               end else begin
                  rBeat_d   = rBeat_q + 4'd1;
                  rAddr_d   = nextAddr(rAddr_q, rSize_q, rLen_q, rBurst_q);
                  rdState_d = R_FETCH;
               end
            end
         end
         default: rdState_d = R_IDLE;
      endcase
   end

   // Read path registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rdState_q <= R_IDLE;
         rId_q     <= '0;
         rAddr_q   <= '0;
         rLen_q    <= '0;
         rSize_q   <= '0;
         rBurst_q  <= '0;
         rBeat_q   <= '0;
         rErr_q    <= 1'b0;
      end else begin
         rdState_q <= rdState_d;
         rId_q     <= rId_d;
         rAddr_q   <= rAddr_d;
         rLen_q    <= rLen_d;
         rSize_q   <= rSize_d;
         rBurst_q  <= rBurst_d;
         rBeat_q   <= rBeat_d;
         rErr_q    <= rErr_d;
      end
   end

   // Write path: beats past len keep being accepted until wlast but are
   // dropped; the beat counter saturates so it cannot wrap back into range.
   always_comb begin
      wrState_d = wrState_q;
      wId_d     = wId_q;
      wAddr_d   = wAddr_q;
      wLen_d    = wLen_q;
      wSize_d   = wSize_q;
      wBurst_d  = wBurst_q;
      wBeat_d   = wBeat_q;
      wErr_d    = wErr_q;
      bErr_d    = bErr_q;
      case (wrState_q)
         W_IDLE: begin
            if (awvalid) begin
               wId_d     = awid;
               wAddr_d   = awaddr;
               wLen_d    = awlen;
               wSize_d   = awsize;
               wBurst_d  = awburst;
               wBeat_d   = 5'd0;
               wErr_d    = isIllegal(awburst, awsize, awlen);
               wrState_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               if (wBeat_q != 5'd16)
                  wBeat_d = wBeat_q + 5'd1;
               wAddr_d = nextAddr(wAddr_q, wSize_q, wLen_q, wBurst_q);
               if (wlast) begin
                  bErr_d    = wErr_q || (wBeat_q != {1'b0, wLen_q});
                  wrState_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bready)
               wrState_d = W_IDLE;
         end
         default: wrState_d = W_IDLE;
      endcase
   end

   // Write path registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wrState_q <= W_IDLE;
         wId_q     <= '0;
         wAddr_q   <= '0;
         wLen_q    <= '0;
         wSize_q   <= '0;
         wBurst_q  <= '0;
         wBeat_q   <= '0;
         wErr_q    <= 1'b0;
         bErr_q    <= 1'b0;
      end else begin
         wrState_q <= wrState_d;
         wId_q     <= wId_d;
         wAddr_q   <= wAddr_d;
         wLen_q    <= wLen_d;
         wSize_q   <= wSize_d;
         wBurst_q  <= wBurst_d;
         wBeat_q   <= wBeat_d;
         wErr_q    <= wErr_d;
         bErr_q    <= bErr_d;
      end
   end

   // Handshake outputs come from state only; reset forces them low so no
   // transfer can complete on a reset edge.
   assign arready = (rdState_q == R_IDLE) && !areset;
   assign rvalid  = (rdState_q == R_DATA) && !areset;
   assign rlast   = (rdState_q == R_DATA) && (rBeat_q == rLen_q);
   assign rid     = rId_q;
   assign rresp   = rErr_q ? RESP_SLVERR : RESP_OKAY;
   assign rdata   = rErr_q ? 32'd0 : memRdata;

   assign awready = (wrState_q == W_IDLE) && !areset;
   assign wready  = (wrState_q == W_DATA) && !areset;
   assign bvalid  = (wrState_q == W_RESP) && !areset;
   assign bid     = wId_q;
   assign bresp   = bErr_q ? RESP_SLVERR : RESP_OKAY;

   assign memRdEn = (rdState_q == R_FETCH);
   assign memWrEn = wready && wvalid && !wErr_q && (wBeat_q <= {1'b0, wLen_q});

   axi_ram_slave_mem #(
      .MEM_AW(MEM_AW)
   ) uMem (
      .clk_i   (aclk),
      .reset_i (areset),
      .wrEn_i  (memWrEn),
      .wrBe_i  (wstrb),
      .wrAddr_i(wAddr_q[MEM_AW+1:2]),
      .wrData_i(wdata),
      .rdEn_i  (memRdEn),
      .rdAddr_i(rAddr_q[MEM_AW+1:2]),
      .rdData_o(memRdata)
   );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Testbench for axi_ram_slave: directed AXI bursts against a cycle-level
// reference of the responder's promised behaviour, plus literal checks.
module tb_axi_ram_slave;
   import axi_slave_pkg::*;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int compared   = 0;
   int mismatched = 0;
   bit modelOn    = 1'b0;

   // Results captured by the stimulus tasks.
   logic [31:0] rdBuf  [16];
   logic [1:0]  rdResp [16];
   bit          rdLast [16];
   int          rdCount;
   int          rdLat;
   logic [3:0]  wrId;
   logic [1:0]  wrResp;

   // Reference memory and what the responder must be doing next cycle.
   logic [31:0] modelMem   [4096];
   bit          modelKnown [4096];
   bit          mrBusy, mrErr, mrSnapKnown;
   int          mrWait, mrBeat, mrLen, mrSize, mrBurst;
   logic [31:0] mrStart, mrSnap;
   logic [3:0]  mrId;
   bit          mwData, mwResp, mwErr, mwRespErr;
   int          mwBeat, mwLen, mwSize, mwBurst;
   logic [31:0] mwStart;
   logic [3:0]  mwId;
   logic [31:0] tmpAddr;
   logic [11:0] tmpIdx;

   axi_ram_slave #(.MEM_AW(12)) dut (
      .aclk(aclk), .areset(areset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte address of beat n of a burst, computed directly from the start.
   function automatic logic [31:0] beatAddr(input logic [31:0] start, input int size,
                                            input int len, input int burst, input int n);
      int unsigned bytes, win, base;
      bytes = 1 << size;
      win   = (len + 1) * bytes;
      if (burst == 1) return start + n * bytes;
      if (burst == 2) begin
         base = start - (start % win);
         return base + ((start - base + n * bytes) % win);
      end
      return start;
   endfunction

   function automatic bit modelIllegal(input int burst, input int size, input int len);
      return (burst == 3) || (size > 2) ||
             ((burst == 2) && !((len + 1 == 2) || (len + 1 == 4) || (len + 1 == 8) || (len + 1 == 16)));
   endfunction

   // Reference: check this cycle's outputs, then advance over the coming edge.
   always @(negedge aclk) begin
      if (modelOn) begin
         checkOutput("arready", arready, !areset && !mrBusy);
         checkOutput("rvalid", rvalid, !areset && mrBusy && mrWait == 0);
         if (!areset && mrBusy && mrWait == 0 && rvalid) begin
            checkOutput("rid", rid, mrId);
            checkOutput("rresp", rresp, mrErr ? 32'd2 : 32'd0);
            checkOutput("rlast", rlast, mrBeat == mrLen);
            if (mrErr)
               checkOutput("rdataErr", rdata, 32'd0);
            else if (mrSnapKnown)
               checkOutput("rdata", rdata, mrSnap);
         end
         checkOutput("awready", awready, !areset && !mwData && !mwResp);
         checkOutput("wready", wready, !areset && mwData);
         checkOutput("bvalid", bvalid, !areset && mwResp);
         if (!areset && mwResp && bvalid) begin
            checkOutput("bid", bid, mwId);
            checkOutput("bresp", bresp, mwRespErr ? 32'd2 : 32'd0);
         end

         if (areset) begin
            mrBusy = 1'b0;
            mwData = 1'b0;
            mwResp = 1'b0;
         end else begin
            if (!mrBusy) begin
               if (arvalid) begin
                  mrBusy  = 1'b1;
                  mrWait  = 1;
                  mrBeat  = 0;
                  mrId    = arid;
                  mrStart = araddr;
                  mrLen   = int'(arlen);
                  mrSize  = int'(arsize);
                  mrBurst = int'(arburst);
                  mrErr   = modelIllegal(mrBurst, mrSize, mrLen);
               end
            end else if (mrWait == 1) begin
               tmpAddr     = beatAddr(mrStart, mrSize, mrLen, mrBurst, mrBeat);
               tmpIdx      = tmpAddr[13:2];
               mrSnap      = modelMem[tmpIdx];
               mrSnapKnown = modelKnown[tmpIdx];
               mrWait      = 0;
            end else if (rready) begin
               if (mrBeat == mrLen) mrBusy = 1'b0;
               else begin
                  mrBeat++;
                  mrWait = 1;
               end
            end

            if (mwResp) begin
               if (bready) mwResp = 1'b0;
            end else if (mwData) begin
               if (wvalid) begin
                  if (!mwErr && mwBeat <= mwLen) begin
                     tmpAddr = beatAddr(mwStart, mwSize, mwLen, mwBurst, mwBeat);
                     tmpIdx  = tmpAddr[13:2];
                     for (int b = 0; b < 4; b++)
                        if (wstrb[b]) modelMem[tmpIdx][8*b +: 8] = wdata[8*b +: 8];
                     if (wstrb == 4'hF) modelKnown[tmpIdx] = 1'b1;
                  end
                  if (wlast) begin
                     mwRespErr = mwErr || (mwBeat != mwLen);
                     mwData    = 1'b0;
                     mwResp    = 1'b1;
                  end
                  mwBeat++;
               end
            end else if (awvalid) begin
               mwData  = 1'b1;
               mwBeat  = 0;
               mwId    = awid;
               mwStart = awaddr;
               mwLen   = int'(awlen);
               mwSize  = int'(awsize);
               mwBurst = int'(awburst);
               mwErr   = modelIllegal(mwBurst, mwSize, mwLen);
            end
         end
      end
   end

   task automatic issueAR(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bit ok = 1'b0;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge aclk);
         if (arready) begin ok = 1'b1; break; end
      end
      checkOutput("arHandshake", ok, 1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   // Collect one read burst; rready stays low for 'hold' cycles of rvalid.
   task automatic collectRead(input int hold);
      bit seen = 1'b0, done = 1'b0;
      int held = 0;
      rdCount = 0; rdLat = 0;
      rready = (hold == 0);
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge aclk);
         if (rvalid && !seen) begin seen = 1'b1; rdLat = c + 1; end
         if (rvalid && rready) begin
            if (rdCount < 16) begin
               rdBuf[rdCount] = rdata; rdResp[rdCount] = rresp; rdLast[rdCount] = rlast;
            end
            rdCount++;
            if (rlast) done = 1'b1;
         end else if (rvalid) begin
            held++;
         end
         @(posedge aclk); #1;
         if (held >= hold) rready = 1'b1;
      end
      rready = 1'b0;
      checkOutput("readDone", done, 1);
   endtask

   task automatic applyRead(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int hold);
      issueAR(id, addr, len, 3'd2, burst);
      collectRead(hold);
   endtask

   task automatic collectB();
      bit ok = 1'b0;
      bready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge aclk);
         if (bvalid) begin ok = 1'b1; wrId = bid; wrResp = bresp; break; end
      end
      checkOutput("bHandshake", ok, 1);
      @(posedge aclk); #1;
      bready = 1'b0;
   endtask

   task automatic applyWrite(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int nBeats,
                             input logic [31:0] base, input logic [3:0] strb);
      bit ok = 1'b0;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge aclk);
         if (awready) begin ok = 1'b1; break; end
      end
      checkOutput("awHandshake", ok, 1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int i = 0; i < nBeats; i++) begin
         wdata = base + i; wstrb = strb; wlast = (i == nBeats - 1); wvalid = 1'b1;
         ok = 1'b0;
         for (int c = 0; c < 50; c++) begin
            @(negedge aclk);
            if (wready) begin ok = 1'b1; break; end
         end
         checkOutput("wHandshake", ok, 1);
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      collectB();
   endtask

   task automatic applyStimulus();
      int hs, rvCount;
      // Reset held for three edges: every output must be zero.
      areset = 1'b1;
      @(posedge aclk); #1;
      modelOn = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      checkOutput("resetCtl", {arready, rvalid, rlast, rid, rresp, awready, wready, bvalid, bid, bresp}, 0);
      checkOutput("resetRdata", rdata, 32'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("postResetReady", {arready, awready}, 2'b11);
      @(posedge aclk); #1;

      // INCR write then read back.
      applyWrite(4'd5, 32'h100, 4'd3, BURST_INCR, 4, 32'hA0, 4'hF);
      checkOutput("incrBid", wrId, 5);
      checkOutput("incrBresp", wrResp, 0);
      applyRead(4'd3, 32'h100, 4'd3, BURST_INCR, 0);
      checkOutput("incrCount", rdCount, 4);
      checkOutput("incrLat", rdLat, 2);
      for (int i = 0; i < 4; i++) checkOutput("incrData", rdBuf[i], 32'hA0 + i);
      checkOutput("incrLast", {rdLast[3], rdLast[2], rdLast[1], rdLast[0]}, 4'b1000);

      // WRAP read from 0x108 visits 0x108, 0x10C, 0x100, 0x104.
      applyRead(4'd6, 32'h108, 4'd3, BURST_WRAP, 0);
      checkOutput("wrap0", rdBuf[0], 32'hA2);
      checkOutput("wrap1", rdBuf[1], 32'hA3);
      checkOutput("wrap2", rdBuf[2], 32'hA0);
      checkOutput("wrap3", rdBuf[3], 32'hA1);

      // Byte strobes 0101 over an all-ones word.
      applyWrite(4'd1, 32'h300, 4'd0, BURST_INCR, 1, 32'hFFFFFFFF, 4'hF);
      applyWrite(4'd1, 32'h300, 4'd0, BURST_INCR, 1, 32'h11223344, 4'b0101);
      applyRead(4'd1, 32'h300, 4'd0, BURST_INCR, 0);
      checkOutput("strobe", rdBuf[0], 32'hFF22FF44);

      // Reserved burst type: four SLVERR beats of zero data.
      applyRead(4'd7, 32'h100, 4'd3, 2'b11, 0);
      checkOutput("errCount", rdCount, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("errResp", rdResp[i], 2);
         checkOutput("errData", rdBuf[i], 0);
      end

      // Early wlast: SLVERR, words after beat 1 untouched.
      applyWrite(4'd2, 32'h200, 4'd3, BURST_INCR, 4, 32'hC0, 4'hF);
      applyWrite(4'd4, 32'h200, 4'd3, BURST_INCR, 2, 32'hD0, 4'hF);
      checkOutput("earlyBresp", wrResp, 2);
      checkOutput("earlyBid", wrId, 4);
      applyRead(4'd2, 32'h200, 4'd3, BURST_INCR, 0);
      checkOutput("early0", rdBuf[0], 32'hD0);
      checkOutput("early1", rdBuf[1], 32'hD1);
      checkOutput("early2", rdBuf[2], 32'hC2);
      checkOutput("early3", rdBuf[3], 32'hC3);

      // Backpressure: rready low for five cycles.
      applyRead(4'd8, 32'h100, 4'd0, BURST_INCR, 5);
      checkOutput("bpData", rdBuf[0], 32'hA0);
      checkOutput("bpLat", rdLat, 2);

      // Read fetch and write beat to 0x300 land on the same edge.
      awid = 4'd9; awaddr = 32'h300; awlen = 4'd0; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      arid = 4'd9; araddr = 32'h300; arlen = 4'd0; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      wdata = 32'h55667788; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      collectRead(0);
      checkOutput("rfOld", rdBuf[0], 32'hFF22FF44);
      collectB();
      checkOutput("rfBresp", wrResp, 0);
      applyRead(4'd9, 32'h300, 4'd0, BURST_INCR, 0);
      checkOutput("rfNew", rdBuf[0], 32'h55667788);

      // Reset while beat 2 of a read is being fetched.
      issueAR(4'd2, 32'h100, 4'd3, 3'd2, BURST_INCR);
      rready = 1'b1;
      hs = 0;
      for (int c = 0; c < 40 && hs < 2; c++) begin
         @(negedge aclk);
         if (rvalid && rready) hs++;
         @(posedge aclk); #1;
      end
      checkOutput("hsBeforeReset", hs, 2);
      areset = 1'b1; rready = 1'b0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      rready = 1'b1;
      rvCount = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         if (rvalid) rvCount++;
      end
      checkOutput("rvalidAfterReset", rvCount, 0);
      @(posedge aclk); #1;
      rready = 1'b0;
      applyRead(4'd1, 32'h104, 4'd0, BURST_INCR, 0);
      checkOutput("memKept", rdBuf[0], 32'hA1);
   endtask

   initial begin
      areset = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      mrBusy = 1'b0; mwData = 1'b0; mwResp = 1'b0;
      applyStimulus();
      repeat (2) @(posedge aclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, giving log2 of the memory depth in 32-bit words.
REQ-002 SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-004 AR channel ports SHALL be: arid in 4, araddr in 32, arlen in 4, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-005 R channel ports SHALL be: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 AW channel ports SHALL be: awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-007 W channel ports SHALL be: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-008 B channel ports SHALL be: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-009 The block SHALL ignore arlock, arcache, arprot, awlock, awcache, awprot and wid.

Function
REQ-010 The block SHALL act as an AXI3 responder with one outstanding read and one outstanding write; the read and write paths SHALL be independent and concurrent.
REQ-011 Word index SHALL be addr[MEM_AW+1:2]; addresses beyond the memory depth alias modulo the depth.
REQ-012 Beat address SHALL advance by 1<<size per handshaked beat: FIXED (00) never advances; INCR (01) advances linearly; WRAP (10) wraps within an aligned window of (len+1)<<size bytes.
REQ-013 A request SHALL be illegal if burst is 11, size is greater than 2, or burst is WRAP with len+1 not in {2,4,8,16}.
REQ-014 Read FSM states SHALL be R_IDLE, R_FETCH and R_DATA. arready=1 only in R_IDLE. On an AR handshake the FSM goes to R_FETCH and latches id, addr, len, size, burst and the beat counter.
REQ-015 In R_FETCH the FSM SHALL issue one memory read and go to R_DATA. In R_DATA, rvalid=1 and rid, rdata, rresp and rlast are held stable until rready.
REQ-016 On an R handshake the FSM SHALL go to R_IDLE if rlast=1, otherwise to R_FETCH. rvalid SHALL rise exactly 2 cycles after the AR handshake, and beats SHALL be at most one per 2 cycles.
REQ-017 rlast SHALL be 1 exactly on beat len, and exactly len+1 beats SHALL be returned.
REQ-018 rdata SHALL be the full 32-bit word, with no lane shifting. For an illegal read, rresp SHALL be SLVERR (10) and rdata SHALL be 0 on every beat; otherwise rresp SHALL be OKAY (00).
REQ-019 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP. awready=1 only in W_IDLE; wready=1 only in W_DATA.
REQ-020 Each W handshake SHALL write the bytes selected by wstrb at the current beat address. If the request is illegal, or the beat count exceeds len, the beat SHALL be dropped.
REQ-021 On a W handshake with wlast=1 the FSM SHALL go to W_RESP. bvalid SHALL be 1 from the next cycle until the B handshake, after which the FSM returns to W_IDLE.
REQ-022 bid SHALL equal the latched awid. bresp SHALL be SLVERR if the request was illegal or wlast arrived on a beat other than len; otherwise OKAY.
REQ-023 A simultaneous memory read and write to the same word SHALL return the old data (read-first).
REQ-024 Handshakes SHALL NOT depend combinationally on the peer's valid or ready; arready, rvalid, awready, wready and bvalid SHALL be decoded from state registers.

Reset
REQ-025 While areset=1 at a clock edge, both FSMs SHALL enter IDLE on that edge.
REQ-026 Reset values: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, awready=0, wready=0, bvalid=0, bid=0, bresp=0. The ready outputs SHALL rise in the first cycle after areset deasserts.
REQ-027 Reset mid-burst SHALL abandon the burst with no further beats or response. Memory contents SHALL NOT be cleared by reset.

Structure
REQ-028 Package axi_slave_pkg SHALL hold the burst encodings (FIXED, INCR, WRAP), the response encodings (OKAY, SLVERR), the read/write FSM state typedefs, and a next-address function.
REQ-029 Sub-module axi_ram_slave_mem SHALL be a simple dual-port synchronous RAM: one write port with a 4-bit byte enable, one read port with 1-cycle latency, read-first behaviour, and depth 2**MEM_AW.

Verification
REQ-030 Reset: with areset=1 for 3 cycles, all outputs = 0; after release, arready=awready=1 in the next cycle.
REQ-031 INCR write: awaddr=0x100, awlen=3, awsize=2, awid=5, beats 0xA0..0xA3 with wstrb=F, then read back the same burst. Required: bid=5 with OKAY; rdata A0, A1, A2, A3; rlast only on the 4th beat; first rvalid 2 cycles after AR.
REQ-032 WRAP read: araddr=0x108, arlen=3, arsize=2, burst=WRAP. Required: words read from 0x108, 0x10C, 0x100, 0x104.
REQ-033 Byte strobe: write 0x11223344 with wstrb=0101 over a word holding 0xFFFFFFFF. Required readback: 0xFF22FF44.
REQ-034 Errors: arburst=11 gives len+1 beats of SLVERR with rdata=0. A write with awlen=3 but wlast on beat 1 gives SLVERR, and memory beyond beat 1 is unchanged.
REQ-035 Backpressure and concurrency: rready low for 5 cycles holds rdata stable; a concurrent read and write to the same word returns the old value; areset during beat 2 of a read produces no further rvalid.
